// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: CPU-side register bus of the UART controller.
//   addr   2   word address (0 DATA, 1 STATUS, 2 CTRL, 3 BAUD)
//   wdata  16  write data
//   we     1   write strobe
//   re     1   read strobe (never together with we)
//   rdata  16  registered read data, valid the cycle after re
// master = bus side (CPU / testbench), slave = uart_ctrl.
interface uart_ctrl_if;
   logic [1:0]  addr;
   logic [15:0] wdata;
   logic        we;
   logic        re;
   logic [15:0] rdata;

   modport master (output addr, output wdata, output we, output re, input rdata);
   modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: register-side front end of the UART.
//   Owns a TX FIFO, an RX FIFO, sticky overflow flags and a 4-word register map, and drives the
//   control inputs of one uart instance. Single clock, synchronous active-low reset.
// Ports:
//   clk, rst          clock and synchronous reset (rst=0 resets)
//   bus               uart_ctrl_if.slave register bus (addr/wdata/we/re/rdata)
//   baudrate          BAUD register          stopbits  CTRL[3:2]
//   rxe, txe          CTRL[0], CTRL[1]       tx_data   last launched byte
//   tx_rdy            one-cycle launch pulse tx_complete byte fully sent
//   rx_data           received byte          rx_complete receive done (level, edge-detected)
//   irq               interrupt
// Optional feature: define UART_CTRL_IRQ_EN to add the IRQEN bits CTRL[6:4] and a live irq;
// without it CTRL[6:4] read 0 and irq is tied low.
module uart_ctrl #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] BAUD_RST   = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   uart_ctrl_if.slave  bus,
   output logic [15:0] baudrate,
   output logic [1:0]  stopbits,
   output logic        rxe,
   output logic        txe,
   output logic [7:0]  tx_data,
   output logic        tx_rdy,
   input  logic        tx_complete,
   input  logic [7:0]  rx_data,
   input  logic        rx_complete,
   output logic        irq
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [0:0] {StIdle, StBusy} tx_state_e;

   tx_state_e   state_q;
   logic [3:0]  ctrl_q;
   logic [15:0] baud_q;
   logic [15:0] rdata_q;
   logic [7:0]  tx_data_q;
   logic        tx_rdy_q;
   logic        rx_prev_q;
   logic        rx_ovr_q, tx_ovr_q;
   logic [AW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
   logic [CW-1:0] rx_cnt_q, tx_cnt_q;
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [7:0]  tx_mem [FIFO_DEPTH];
`ifdef UART_CTRL_IRQ_EN
   logic [2:0]  irqen_q;  // {txidle_en, ovr_en, rx_en}
   logic        irq_q;
`endif

   logic rx_empty, rx_full, tx_empty, tx_full, tx_busy;
   logic rd_data, wr_data;
   logic rx_edge, rx_pop, rx_push, rx_drop;
   logic tx_launch, tx_push, tx_drop;
   logic [15:0] status, ctrl_rd, rd_val;

   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
   assign tx_busy  = (state_q == StBusy);

   assign rd_data = bus.re && (bus.addr == 2'd0);
   assign wr_data = bus.we && (bus.addr == 2'd0);

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign rx_edge = rx_complete && !rx_prev_q && ctrl_q[0];
   assign rx_pop  = rd_data && !rx_empty;
   assign rx_push = rx_edge && (!rx_full || rx_pop);
   assign rx_drop = rx_edge && rx_full && !rx_pop;

   assign tx_launch = (state_q == StIdle) && ctrl_q[1] && !tx_empty;
   assign tx_push   = wr_data && (!tx_full || tx_launch);
   assign tx_drop   = wr_data && tx_full && !tx_launch;

   assign status = {8'h00, tx_ovr_q, rx_ovr_q, tx_busy, tx_full, tx_empty, rx_full, rx_empty, 1'b0};
`ifdef UART_CTRL_IRQ_EN
   assign ctrl_rd = {9'h000, irqen_q, ctrl_q};
`else
   assign ctrl_rd = {12'h000, ctrl_q};
`endif

   always_comb begin
      rd_val = '0;
      case (bus.addr)
         2'd0:    if (!rx_empty) rd_val = {8'h00, rx_mem[rx_rd_q]};
         2'd1:    rd_val = status;
         2'd2:    rd_val = ctrl_rd;
         default: rd_val = baud_q;
      endcase
   end

   // FIFO storage needs no reset; pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_q] <= rx_data;
      if (tx_push) tx_mem[tx_wr_q] <= bus.wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         ctrl_q    <= '0;
         baud_q    <= BAUD_RST;
         rdata_q   <= '0;
         tx_data_q <= '0;
         tx_rdy_q  <= 1'b0;
         rx_prev_q <= 1'b0;
         rx_ovr_q  <= 1'b0;
         tx_ovr_q  <= 1'b0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         tx_cnt_q  <= '0;
`ifdef UART_CTRL_IRQ_EN
         irqen_q   <= '0;
         irq_q     <= 1'b0;
`endif
      end else begin
         rx_prev_q <= rx_complete;
         tx_rdy_q  <= 1'b0;

         if (bus.we) begin
            case (bus.addr)
               2'd1: begin
                  if (bus.wdata[6]) rx_ovr_q <= 1'b0;
                  if (bus.wdata[7]) tx_ovr_q <= 1'b0;
               end
               2'd2: begin
                  ctrl_q <= bus.wdata[3:0];
`ifdef UART_CTRL_IRQ_EN
                  irqen_q <= bus.wdata[6:4];
`endif
               end
               2'd3:    baud_q <= bus.wdata;
               default: ;  // DATA writes go through tx_push
            endcase
         end

         // A new overflow in the same cycle as a clear keeps the flag set.
         if (rx_drop) rx_ovr_q <= 1'b1;
         if (tx_drop) tx_ovr_q <= 1'b1;

         if (bus.re) rdata_q <= rd_val;

         if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
         if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
         rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

         if (tx_push)   tx_wr_q <= tx_wr_q + AW'(1);
         if (tx_launch) tx_rd_q <= tx_rd_q + AW'(1);
         tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_launch);

         case (state_q)
            StIdle: begin
               if (tx_launch) begin
                  tx_data_q <= tx_mem[tx_rd_q];
                  tx_rdy_q  <= 1'b1;
                  state_q   <= StBusy;
               end
            end
            StBusy: begin
               // Dropping txe abandons the in-flight byte.
               if (!ctrl_q[1] || tx_complete) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

`ifdef UART_CTRL_IRQ_EN
         irq_q <= (irqen_q[0] & ~rx_empty) | (irqen_q[1] & (rx_ovr_q | tx_ovr_q)) |
                  (irqen_q[2] & tx_empty & ~tx_busy);
`endif
      end
   end

   assign bus.rdata = rdata_q;
   assign baudrate  = baud_q;
   assign stopbits  = ctrl_q[3:2];
   assign txe       = ctrl_q[1];
   assign rxe       = ctrl_q[0];
   assign tx_data   = tx_data_q;
   assign tx_rdy    = tx_rdy_q;
`ifdef UART_CTRL_IRQ_EN
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl. Register vectors come from a table; TX bytes
// and RX bytes are tracked in scoreboard queues; multi-cycle corners are hand-written sequences.
// All bench tasks start and end on a falling clock edge.
module tb_uart_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] baudrate;
   logic [1:0]  stopbits;
   logic        rxe, txe, tx_rdy, irq;
   logic [7:0]  tx_data;
   logic        tx_complete = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_complete = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  tx_exp [$];
   logic [7:0]  rx_exp [$];
   logic [15:0] rd_exp [$];

   always #5 clk = ~clk;

   uart_ctrl_if bus ();

   uart_ctrl #(
      .FIFO_DEPTH (8),
      .BAUD_RST   (16'd434)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .baudrate    (baudrate),
      .stopbits    (stopbits),
      .rxe         (rxe),
      .txe         (txe),
      .tx_data     (tx_data),
      .tx_rdy      (tx_rdy),
      .tx_complete (tx_complete),
      .rx_data     (rx_data),
      .rx_complete (rx_complete),
      .irq         (irq)
   );

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Every tx_rdy pulse must match the oldest expected byte.
   always @(negedge clk) begin
      if (rst && tx_rdy) begin
         if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got tx_rdy with %h want no launch", tx_data);
         end else begin
            check("tx_data", 16'(tx_data), 16'(tx_exp[0]));
            void'(tx_exp.pop_front());
         end
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      bus.we = 1'b1;
      bus.addr = a;
      bus.wdata = d;
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [15:0] exp, input string name);
      rd_exp.push_back(exp);
      bus.re = 1'b1;
      bus.addr = a;
      @(negedge clk);
      bus.re = 1'b0;
      check(name, bus.rdata, rd_exp.pop_front());
   endtask

   task automatic wait_tx_rdy(input int budget, input string name);
      int n = 0;
      while (!tx_rdy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!tx_rdy) begin
         checks++;
         errors++;
         $display("FAIL %s: tx_rdy=0 after %0d cycles want 1", name, budget);
      end
   endtask

   task automatic tx_done();
      tx_complete = 1'b1;
      @(negedge clk);
      tx_complete = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] v);
      rx_data = v;
      rx_complete = 1'b1;
      @(negedge clk);
      rx_complete = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ctrl_rb;
`ifdef UART_CTRL_IRQ_EN
      ctrl_rb = 16'h007C;
`else
      ctrl_rb = 16'h000C;
`endif
      vecs[0]  = '{1'b0, 2'd1, 16'h0000, 16'h000A};
      vecs[1]  = '{1'b0, 2'd3, 16'h0000, 16'd434};
      vecs[2]  = '{1'b0, 2'd2, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};  // empty RX reads 0
      vecs[4]  = '{1'b1, 2'd3, 16'hBEEF, 16'h0000};
      vecs[5]  = '{1'b0, 2'd3, 16'h0000, 16'hBEEF};
      vecs[6]  = '{1'b1, 2'd2, 16'hFFFC, 16'h0000};
      vecs[7]  = '{1'b0, 2'd2, 16'h0000, ctrl_rb};
      vecs[8]  = '{1'b1, 2'd1, 16'hFFFF, 16'h0000};
      vecs[9]  = '{1'b0, 2'd1, 16'h0000, 16'h000A};
      vecs[10] = '{1'b1, 2'd2, 16'h0000, 16'h0000};
      vecs[11] = '{1'b0, 2'd2, 16'h0000, 16'h0000};
      vecs[12] = '{1'b1, 2'd3, 16'd434,  16'h0000};

      bus.we = 1'b0;
      bus.re = 1'b0;
      bus.addr = 2'd0;
      bus.wdata = 16'h0000;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_baudrate", baudrate, 16'd434);
      check("rst_stopbits", 16'(stopbits), 16'h0000);
      check("rst_rxe_txe", 16'({rxe, txe}), 16'h0000);
      check("rst_tx_data", 16'(tx_data), 16'h0000);
      check("rst_tx_rdy", 16'(tx_rdy), 16'h0000);
      check("rst_irq", 16'(irq), 16'h0000);
      check("rst_rdata", bus.rdata, 16'h0000);
      rst = 1'b1;
      @(negedge clk);

      // Register map vectors
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
         else bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
      bus_write(2'd3, 16'h1357);
      check("baud_immediate", baudrate, 16'h1357);
      bus_write(2'd2, 16'h000E);
      check("ctrl_outputs", 16'({stopbits, txe, rxe}), 16'h000E);
      bus_write(2'd2, 16'h0000);
      bus_write(2'd3, 16'd434);

      // TX two bytes back to back
      bus_write(2'd2, 16'h0002);
      tx_exp.push_back(8'h55);
      tx_exp.push_back(8'hAA);
      bus_write(2'd0, 16'h0055);
      bus_write(2'd0, 16'h00AA);
      wait_tx_rdy(20, "tx_first");
      bus_read(2'd1, 16'h0022, "status_busy");
      tx_done();
      wait_tx_rdy(20, "tx_second");
      tx_done();
      bus_read(2'd1, 16'h000A, "status_tx_idle");

      // txe dropped while busy
      bus_write(2'd2, 16'h0000);
      bus_write(2'd0, 16'h0001);
      bus_write(2'd0, 16'h0002);
      bus_write(2'd0, 16'h0003);
      tx_exp.push_back(8'h01);
      bus_write(2'd2, 16'h0002);
      wait_tx_rdy(20, "tx_abort_launch");
      bus_write(2'd2, 16'h0000);
      repeat (5) @(negedge clk);
      bus_read(2'd1, 16'h0002, "status_txe_off");
      tx_exp.push_back(8'h02);
      tx_exp.push_back(8'h03);
      bus_write(2'd2, 16'h0002);
      wait_tx_rdy(20, "tx_resume1");
      tx_done();
      wait_tx_rdy(20, "tx_resume2");
      tx_done();
      bus_read(2'd1, 16'h000A, "status_resume_done");

      // TX FIFO overflow
      bus_write(2'd2, 16'h0000);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) tx_exp.push_back(8'hA0 + 8'(i));
         bus_write(2'd0, 16'hA0 + 16'(i));
      end
      bus_read(2'd1, 16'h0092, "status_txovr");
      bus_write(2'd1, 16'h0080);
      bus_read(2'd1, 16'h0012, "status_txovr_clr");
      bus_write(2'd2, 16'h0002);
      for (int i = 0; i < 8; i++) begin
         wait_tx_rdy(20, "tx_drain");
         tx_done();
      end
      bus_write(2'd2, 16'h0000);
      check("tx_queue_drained", 16'(tx_exp.size()), 16'h0000);

      // RX level held 3 cycles -> one byte
      bus_write(2'd2, 16'h0001);
      rx_data = 8'h3C;
      rx_complete = 1'b1;
      repeat (3) @(negedge clk);
      rx_complete = 1'b0;
      @(negedge clk);
      bus_read(2'd1, 16'h0008, "status_rx_one");
      bus_read(2'd0, 16'h003C, "rx_data_3c");
      bus_read(2'd1, 16'h000A, "status_rx_single");

      // RX overflow
      for (int i = 0; i < 9; i++) begin
         if (i < 8) rx_exp.push_back(8'h10 + 8'(i));
         rx_byte(8'h10 + 8'(i));
      end
      bus_read(2'd1, 16'h004C, "status_rxovr");
      check("irq_no_enable", 16'(irq), 16'h0000);
      for (int i = 0; i < 8; i++) bus_read(2'd0, 16'(rx_exp.pop_front()), "rx_order");
      bus_read(2'd1, 16'h004A, "status_rxovr_sticky");
      bus_write(2'd1, 16'h0040);
      bus_read(2'd1, 16'h000A, "status_rxovr_clr");

      // Full RX FIFO: pop and capture in the same cycle
      for (int i = 0; i < 8; i++) begin
         rx_exp.push_back(8'h20 + 8'(i));
         rx_byte(8'h20 + 8'(i));
      end
      rx_exp.push_back(8'h99);
      bus.re = 1'b1;
      bus.addr = 2'd0;
      rx_data = 8'h99;
      rx_complete = 1'b1;
      @(negedge clk);
      bus.re = 1'b0;
      rx_complete = 1'b0;
      check("rx_pop_push", bus.rdata, 16'(rx_exp.pop_front()));
      @(negedge clk);
      bus_read(2'd1, 16'h000C, "status_full_no_ovr");
      for (int i = 0; i < 8; i++) bus_read(2'd0, 16'(rx_exp.pop_front()), "rx_order2");
      bus_read(2'd1, 16'h000A, "status_rx_drained");

`ifdef UART_CTRL_IRQ_EN
      bus_write(2'd2, 16'h0011);
      rx_byte(8'h5A);
      check("irq_rx", 16'(irq), 16'h0001);
      bus_read(2'd0, 16'h005A, "irq_rx_data");
      @(negedge clk);
      check("irq_clear", 16'(irq), 16'h0000);
`endif

      check("rx_queue_drained", 16'(rx_exp.size()), 16'h0000);
      check("tx_queue_final", 16'(tx_exp.size()), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
